// File: rtl/dcache_defs.sv
// Shared definitions for the blocking data-cache controller:
// bus commands, FSM states, field widths and address slicing helpers.
package dcache_defs;

    localparam int ADDR_W    = 32;
    localparam int MEM_TAG_W = 4;
    localparam int TAG_W     = 22;
    localparam int IDX_W     = 7;
    localparam int DATA_W    = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FETCH,
        S_WAIT,
        S_FILL
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[31:10];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[9:3];
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0] t,
        input logic [IDX_W-1:0] i
    );
        return {t, i, 3'b000};
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of LSU request/response, cache array and memory bus signals.
// master = controller side, slave = LSU/array/memory side.
interface dcache_ctrl_if;
    import dcache_defs::*;

    logic                 req_valid;
    logic                 req_store;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_data;
    logic                 req_ready;
    logic                 resp_valid;
    logic [DATA_W-1:0]    resp_data;

    logic [TAG_W-1:0]     cm_rd_tag;
    logic [IDX_W-1:0]     cm_rd_idx;
    logic [DATA_W-1:0]    cm_rd_data;
    logic                 cm_rd_valid;
    logic [TAG_W-1:0]     cm_victim_tag;
    logic [DATA_W-1:0]    cm_victim_data;
    logic                 cm_victim_dirty;

    logic                 cm_wr1_en;
    logic [TAG_W-1:0]     cm_wr1_tag;
    logic [IDX_W-1:0]     cm_wr1_idx;
    logic [DATA_W-1:0]    cm_wr1_data;
    logic                 cm_wr0_en;
    logic [TAG_W-1:0]     cm_wr0_tag;
    logic [IDX_W-1:0]     cm_wr0_idx;
    logic [DATA_W-1:0]    cm_wr0_data;

    logic [1:0]           proc2mem_command;
    logic [ADDR_W-1:0]    proc2mem_addr;
    logic [DATA_W-1:0]    proc2mem_data;
    logic [MEM_TAG_W-1:0] mem2proc_response;
    logic [MEM_TAG_W-1:0] mem2proc_tag;
    logic [DATA_W-1:0]    mem2proc_data;

    modport master (
        input  req_valid, req_store, req_addr, req_data,
        output req_ready, resp_valid, resp_data,
        output cm_rd_tag, cm_rd_idx,
        input  cm_rd_data, cm_rd_valid,
        input  cm_victim_tag, cm_victim_data, cm_victim_dirty,
        output cm_wr1_en, cm_wr1_tag, cm_wr1_idx, cm_wr1_data,
        output cm_wr0_en, cm_wr0_tag, cm_wr0_idx, cm_wr0_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data
    );

    modport slave (
        output req_valid, req_store, req_addr, req_data,
        input  req_ready, resp_valid, resp_data,
        input  cm_rd_tag, cm_rd_idx,
        output cm_rd_data, cm_rd_valid,
        output cm_victim_tag, cm_victim_data, cm_victim_dirty,
        input  cm_wr1_en, cm_wr1_tag, cm_wr1_idx, cm_wr1_data,
        input  cm_wr0_en, cm_wr0_tag, cm_wr0_idx, cm_wr0_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data
    );

endinterface

// File: rtl/dcache_mshr.sv
// Single-entry miss register: request line, store flag/data,
// outstanding memory tag and the returned fill data.
module dcache_mshr
    import dcache_defs::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cap_en,
    input  logic [TAG_W-1:0]     cap_tag,
    input  logic [IDX_W-1:0]     cap_idx,
    input  logic                 cap_store,
    input  logic [DATA_W-1:0]    cap_data,
    input  logic                 pend_en,
    input  logic [MEM_TAG_W-1:0] pend_in,
    input  logic                 fill_en,
    input  logic [DATA_W-1:0]    fill_in,
    output logic [TAG_W-1:0]     tag,
    output logic [IDX_W-1:0]     idx,
    output logic                 store,
    output logic [DATA_W-1:0]    data,
    output logic [MEM_TAG_W-1:0] pend_tag,
    output logic [DATA_W-1:0]    fill_data
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag       <= '0;
            idx       <= '0;
            store     <= 1'b0;
            data      <= '0;
            pend_tag  <= '0;
            fill_data <= '0;
        end else begin
            if (cap_en) begin
                tag      <= cap_tag;
                idx      <= cap_idx;
                store    <= cap_store;
                data     <= cap_data;
                pend_tag <= '0;
            end
            if (pend_en) pend_tag  <= pend_in;
            if (fill_en) fill_data <= fill_in;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking single-miss data-cache controller: hit path, dirty
// write-back, line fetch over the tagged memory bus and refill.
module dcache_ctrl
    import dcache_defs::*;
(
    input  logic         clock,
    input  logic         reset,
    dcache_ctrl_if.master bus
);

    state_e               state;
    logic [TAG_W-1:0]     m_tag;
    logic [IDX_W-1:0]     m_idx;
    logic                 m_store;
    logic [DATA_W-1:0]    m_data;
    logic [MEM_TAG_W-1:0] m_pend;
    logic [DATA_W-1:0]    m_fill;
    logic                 idle;
    logic                 accept;
    logic                 dirty_miss;
    logic                 bus_ack;
    logic                 tag_hit;

    assign idle       = (state == S_IDLE);
    assign accept     = idle && bus.req_valid;
    assign bus.cm_rd_tag = idle ? addr_tag(bus.req_addr) : m_tag;
    assign bus.cm_rd_idx = idle ? addr_idx(bus.req_addr) : m_idx;
    assign dirty_miss = !bus.cm_rd_valid && bus.cm_victim_dirty
                        && (bus.cm_victim_tag != bus.cm_rd_tag);
    assign bus_ack    = (bus.mem2proc_response != '0);
    assign tag_hit    = (state == S_WAIT) && (m_pend != '0)
                        && (bus.mem2proc_tag == m_pend);

    dcache_mshr u_mshr (
        .clock     (clock),
        .reset     (reset),
        .cap_en    (accept),
        .cap_tag   (bus.cm_rd_tag),
        .cap_idx   (bus.cm_rd_idx),
        .cap_store (bus.req_store),
        .cap_data  (bus.req_data),
        .pend_en   ((state == S_FETCH) && bus_ack),
        .pend_in   (bus.mem2proc_response),
        .fill_en   (tag_hit),
        .fill_in   (bus.mem2proc_data),
        .tag       (m_tag),
        .idx       (m_idx),
        .store     (m_store),
        .data      (m_data),
        .pend_tag  (m_pend),
        .fill_data (m_fill)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            bus.req_ready        <= 1'b1;
            bus.resp_valid       <= 1'b0;
            bus.resp_data        <= '0;
            bus.cm_wr1_en        <= 1'b0;
            bus.cm_wr1_tag       <= '0;
            bus.cm_wr1_idx       <= '0;
            bus.cm_wr1_data      <= '0;
            bus.cm_wr0_en        <= 1'b0;
            bus.cm_wr0_tag       <= '0;
            bus.cm_wr0_idx       <= '0;
            bus.cm_wr0_data      <= '0;
            bus.proc2mem_command <= BUS_NONE;
            bus.proc2mem_addr    <= '0;
            bus.proc2mem_data    <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.cm_wr1_en  <= 1'b0;
            bus.cm_wr0_en  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        // a clean store miss allocates the whole quadword
                        if (bus.cm_rd_valid || (bus.req_store && !dirty_miss)) begin
                            bus.resp_valid <= 1'b1;
                            if (bus.req_store) begin
                                bus.cm_wr1_en   <= 1'b1;
                                bus.cm_wr1_tag  <= bus.cm_rd_tag;
                                bus.cm_wr1_idx  <= bus.cm_rd_idx;
                                bus.cm_wr1_data <= bus.req_data;
                                bus.resp_data   <= '0;
                            end else begin
                                bus.resp_data   <= bus.cm_rd_data;
                            end
                        end else if (dirty_miss) begin
                            state                <= S_WB;
                            bus.req_ready        <= 1'b0;
                            bus.proc2mem_command <= BUS_STORE;
                            bus.proc2mem_addr    <= line_addr(bus.cm_victim_tag,
                                                              bus.cm_rd_idx);
                            bus.proc2mem_data    <= bus.cm_victim_data;
                        end else begin
                            state                <= S_FETCH;
                            bus.req_ready        <= 1'b0;
                            bus.proc2mem_command <= BUS_LOAD;
                            bus.proc2mem_addr    <= line_addr(bus.cm_rd_tag,
                                                              bus.cm_rd_idx);
                        end
                    end
                end
                S_WB: begin
                    if (bus_ack) begin
                        bus.proc2mem_data <= '0;
                        if (m_store) begin
                            state                <= S_IDLE;
                            bus.req_ready        <= 1'b1;
                            bus.resp_valid       <= 1'b1;
                            bus.resp_data        <= '0;
                            bus.cm_wr1_en        <= 1'b1;
                            bus.cm_wr1_tag       <= m_tag;
                            bus.cm_wr1_idx       <= m_idx;
                            bus.cm_wr1_data      <= m_data;
                            bus.proc2mem_command <= BUS_NONE;
                        end else begin
                            state                <= S_FETCH;
                            bus.proc2mem_command <= BUS_LOAD;
                            bus.proc2mem_addr    <= line_addr(m_tag, m_idx);
                        end
                    end
                end
                S_FETCH: begin
                    if (bus_ack) begin
                        state                <= S_WAIT;
                        bus.proc2mem_command <= BUS_NONE;
                    end
                end
                S_WAIT: begin
                    if (tag_hit) begin
                        state           <= S_FILL;
                        bus.cm_wr0_en   <= 1'b1;
                        bus.cm_wr0_tag  <= m_tag;
                        bus.cm_wr0_idx  <= m_idx;
                        bus.cm_wr0_data <= bus.mem2proc_data;
                    end
                end
                S_FILL: begin
                    state          <= S_IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    bus.resp_data  <= m_fill;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a cache-array model and a
// response scoreboard.
module tb_dcache_ctrl;
    import dcache_defs::*;

    logic clock;
    logic reset;
    dcache_ctrl_if bus();

    dcache_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [TAG_W-1:0]  t_a [128];
    logic [DATA_W-1:0] d_a [128];
    logic              v_a [128];
    logic              y_a [128];

    assign bus.cm_rd_valid     = v_a[bus.cm_rd_idx] && (t_a[bus.cm_rd_idx] == bus.cm_rd_tag);
    assign bus.cm_rd_data      = d_a[bus.cm_rd_idx];
    assign bus.cm_victim_tag   = t_a[bus.cm_rd_idx];
    assign bus.cm_victim_data  = d_a[bus.cm_rd_idx];
    assign bus.cm_victim_dirty = v_a[bus.cm_rd_idx] && y_a[bus.cm_rd_idx];

    always @(posedge clock) begin
        if (bus.cm_wr1_en) begin
            t_a[bus.cm_wr1_idx] <= bus.cm_wr1_tag;
            d_a[bus.cm_wr1_idx] <= bus.cm_wr1_data;
            v_a[bus.cm_wr1_idx] <= 1'b1;
            y_a[bus.cm_wr1_idx] <= 1'b1;
        end
        if (bus.cm_wr0_en) begin
            t_a[bus.cm_wr0_idx] <= bus.cm_wr0_tag;
            d_a[bus.cm_wr0_idx] <= bus.cm_wr0_data;
            v_a[bus.cm_wr0_idx] <= 1'b1;
            y_a[bus.cm_wr0_idx] <= 1'b0;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_resp = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (reset) chk("wr_excl", 64'(bus.cm_wr0_en & bus.cm_wr1_en), 64'd0);
        if (bus.resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0) chk("resp_extra", 64'd1, 64'd0);
            else chk("resp_data", bus.resp_data, exp_q.pop_front());
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic st, input logic [31:0] a, input logic [63:0] d);
        bus.req_valid = 1'b1;
        bus.req_store = st;
        bus.req_addr  = a;
        bus.req_data  = d;
    endtask

    int r0;

    initial begin
        for (int i = 0; i < 128; i++) begin
            t_a[i] = '0; d_a[i] = '0; v_a[i] = 1'b0; y_a[i] = 1'b0;
        end
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0;
        bus.req_addr = '0; bus.req_data = '0;
        bus.mem2proc_response = '0; bus.mem2proc_tag = '0; bus.mem2proc_data = '0;

        cyc();
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rv", 64'(bus.resp_valid), 64'd0);
        chk("rst_rdata", bus.resp_data, 64'd0);
        chk("rst_cmd", 64'(bus.proc2mem_command), 64'd0);
        chk("rst_maddr", 64'(bus.proc2mem_addr), 64'd0);
        chk("rst_mdata", bus.proc2mem_data, 64'd0);
        chk("rst_wr", 64'({bus.cm_wr0_en, bus.cm_wr1_en}), 64'd0);
        reset = 1'b1;
        cyc();

        // clean store miss allocates directly, then load hits
        send(1'b1, 32'h408, 64'h1111); exp_q.push_back(64'h0);
        cyc(); bus.req_valid = 1'b0;
        chk("st_wr1_en", 64'(bus.cm_wr1_en), 64'd1);
        chk("st_wr1_idx", 64'(bus.cm_wr1_idx), 64'd1);
        chk("st_wr1_tag", 64'(bus.cm_wr1_tag), 64'd1);
        chk("st_wr1_data", bus.cm_wr1_data, 64'h1111);
        chk("st_rv", 64'(bus.resp_valid), 64'd1);
        chk("st_nobus", 64'(bus.proc2mem_command), 64'd0);
        cyc();
        send(1'b0, 32'h408, 64'h0); exp_q.push_back(64'h1111);
        cyc(); bus.req_valid = 1'b0;
        chk("ld_hit_rv", 64'(bus.resp_valid), 64'd1);
        chk("ld_hit_nowr", 64'(bus.cm_wr1_en), 64'd0);

        // clean load miss with one retry and a delayed tag
        cyc();
        send(1'b0, 32'h800, 64'h0); exp_q.push_back(64'hABCD);
        cyc(); bus.req_valid = 1'b0;
        chk("lm_cmd", 64'(bus.proc2mem_command), 64'd1);
        chk("lm_addr", 64'(bus.proc2mem_addr), 64'h800);
        chk("lm_ready", 64'(bus.req_ready), 64'd0);
        cyc();
        chk("lm_retry_cmd", 64'(bus.proc2mem_command), 64'd1);
        bus.mem2proc_response = 4'd5;
        bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'hDEAD;
        cyc();
        bus.mem2proc_response = '0; bus.mem2proc_tag = '0;
        chk("lm_wait_cmd", 64'(bus.proc2mem_command), 64'd0);
        cyc(2);
        chk("lm_early_tag", 64'(bus.cm_wr0_en), 64'd0);
        chk("lm_wait_ready", 64'(bus.req_ready), 64'd0);
        cyc(7);
        bus.mem2proc_tag = 4'd5; bus.mem2proc_data = 64'hABCD;
        cyc();
        bus.mem2proc_tag = '0; bus.mem2proc_data = '0;
        chk("lm_wr0_en", 64'(bus.cm_wr0_en), 64'd1);
        chk("lm_wr0_idx", 64'(bus.cm_wr0_idx), 64'd0);
        chk("lm_wr0_tag", 64'(bus.cm_wr0_tag), 64'd2);
        chk("lm_wr0_data", bus.cm_wr0_data, 64'hABCD);
        chk("lm_fill_norv", 64'(bus.resp_valid), 64'd0);
        cyc();
        chk("lm_rv", 64'(bus.resp_valid), 64'd1);
        chk("lm_ready_back", 64'(bus.req_ready), 64'd1);

        // dirty the line, then a conflicting load forces a write-back
        cyc();
        send(1'b1, 32'h800, 64'h77); exp_q.push_back(64'h0);
        cyc(); bus.req_valid = 1'b0;
        cyc();
        send(1'b0, 32'hC00, 64'h0); exp_q.push_back(64'hCC);
        cyc(); bus.req_valid = 1'b0;
        chk("wb_cmd", 64'(bus.proc2mem_command), 64'd2);
        chk("wb_addr", 64'(bus.proc2mem_addr), 64'h800);
        chk("wb_data", bus.proc2mem_data, 64'h77);
        cyc();
        chk("wb_retry_cmd", 64'(bus.proc2mem_command), 64'd2);
        bus.mem2proc_response = 4'd1;
        cyc();
        bus.mem2proc_response = 4'd0;
        chk("wbf_cmd", 64'(bus.proc2mem_command), 64'd1);
        chk("wbf_addr", 64'(bus.proc2mem_addr), 64'hC00);
        bus.mem2proc_response = 4'd2;
        cyc();
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'hCC;
        cyc();
        bus.mem2proc_tag = '0;
        chk("wbf_wr0_en", 64'(bus.cm_wr0_en), 64'd1);
        chk("wbf_wr0_tag", 64'(bus.cm_wr0_tag), 64'd3);
        cyc(2);

        // store miss over a clean victim: no bus traffic
        send(1'b1, 32'h1000, 64'h55); exp_q.push_back(64'h0);
        cyc(); bus.req_valid = 1'b0;
        chk("sm_wr1_en", 64'(bus.cm_wr1_en), 64'd1);
        chk("sm_wr1_tag", 64'(bus.cm_wr1_tag), 64'd4);
        chk("sm_nobus", 64'(bus.proc2mem_command), 64'd0);
        chk("sm_rv", 64'(bus.resp_valid), 64'd1);
        cyc();

        // back-to-back hits
        r0 = n_resp;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("b2b_rv", 64'(bus.resp_valid), 64'd1);
            chk("b2b_ready", 64'(bus.req_ready), 64'd1);
            if (i[0]) begin
                send(1'b0, 32'h408, 64'h0); exp_q.push_back(64'h1111);
            end else begin
                send(1'b0, 32'h1000, 64'h0); exp_q.push_back(64'h55);
            end
            cyc();
        end
        bus.req_valid = 1'b0;
        chk("b2b_last_rv", 64'(bus.resp_valid), 64'd1);
        cyc();
        chk("b2b_count", 64'(n_resp - r0), 64'd8);

        // reset mid-WAIT abandons the miss
        send(1'b0, 32'h2018, 64'h0);
        cyc(); bus.req_valid = 1'b0;
        bus.mem2proc_response = 4'd3;
        cyc();
        bus.mem2proc_response = 4'd0;
        chk("rw_ready", 64'(bus.req_ready), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("rw_rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rw_rst_cmd", 64'(bus.proc2mem_command), 64'd0);
        cyc();
        reset = 1'b1;
        bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hBAD;
        cyc();
        bus.mem2proc_tag = '0;
        chk("rw_no_fill", 64'(bus.cm_wr0_en), 64'd0);
        cyc(2);
        chk("rw_no_rv", 64'(bus.resp_valid), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Single-miss blocking controller for the 128-entry x 64-bit direct-mapped data cache memory. It sits between the load/store unit and the cache data/tag array: it decodes quadword requests into tag/index, looks them up, and writes store hits through the array's wr1 port. On a miss it writes back a dirty victim and fetches the line over the tagged memory bus, filling through the array's wr0 port. One request is in flight at a time.

## Interface
- ADDR_W, 32: byte address width; tag = addr[31:10], idx = addr[9:3], addr[2:0] ignored (quadword access only)
- MEM_TAG_W, 4: memory transaction tag width; tag 0 means "not accepted"
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_valid  in  1  LSU request present
- req_store  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_data  in  64  store data
- req_ready  out  1  controller idle and able to accept
- resp_valid  out  1  one-cycle pulse: load data valid / store complete
- resp_data  out  64  load data (0 for stores)
- cm_rd_tag, cm_rd_idx  out  22, 7  lookup to array
- cm_rd_data  in  64; cm_rd_valid  in  1  array lookup result (combinational)
- cm_victim_tag  in  22; cm_victim_data  in  64; cm_victim_dirty  in  1  resident line at cm_rd_idx
- cm_wr1_en/tag/idx/data  out  1/22/7/64  store write port
- cm_wr0_en/tag/idx/data  out  1/22/7/64  fill write port
- proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- proc2mem_addr  out  32; proc2mem_data  out  64
- mem2proc_response  in  4; mem2proc_tag  in  4; mem2proc_data  in  64

## Operation
- States: IDLE, WB, FETCH, WAIT, FILL.
- IDLE: req_ready=1. On req_valid, register the request. cm_rd_* are driven from req_addr combinationally in IDLE and from the registered request otherwise.
  - Hit (cm_rd_valid): load returns cm_rd_data; store pulses cm_wr1_en with req_data. Stay in IDLE.
  - Miss with valid dirty victim and differing tag: go to WB.
  - Other load miss: go to FETCH.
  - Other store miss: write wr1 directly (full-quadword write-allocate, no fetch), respond, stay in IDLE.
- WB: drive BUS_STORE, addr {victim_tag, idx, 3'b0}, victim data. On nonzero mem2proc_response: a load goes to FETCH; a store writes wr1, responds, and returns to IDLE. On zero response, re-issue next cycle.
- FETCH: drive BUS_LOAD with the request address. On nonzero response, latch it as pend_tag and go to WAIT. On zero response, retry.
- WAIT: bus idle. When mem2proc_tag == pend_tag (nonzero), latch mem2proc_data and go to FILL.
- FILL: pulse cm_wr0_en with the registered tag, idx and latched data, then return to IDLE.
- A response from FILL is always a load: resp_data = fill data, resp_valid pulses, and the state returns to IDLE.
- cm_wr0_en and cm_wr1_en are never asserted in the same cycle.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_data 0, all cm_wr*_en 0, proc2mem_command BUS_NONE, proc2mem_addr 0, proc2mem_data 0, pend_tag 0.
- Hit: request accepted at edge N; resp_valid registered, high in cycle N+1. A new request may be accepted at edge N+1 (back-to-back hits: 1/cycle).
- Clean load miss: accept N; FETCH in N+1 (command visible); WAIT from the edge where the response is nonzero; FILL the cycle after the tag match; resp_valid the cycle after FILL.
- Dirty miss adds the WB cycles, including retries, before FETCH.
- mem2proc_tag matching pend_tag is only honoured in WAIT. A matching tag in the same cycle the response is latched is ignored.
- Reset asserted mid-miss abandons the transaction and returns to IDLE. A late memory tag arriving after reset is ignored because pend_tag = 0.

## Structure
- Shared package/header `dcache_defs`: BUS_* command encodings, state encodings, TAG_W=22, IDX_W=7, field-slicing macros.
- One natural sub-module: `dcache_mshr`, a single-entry miss register holding addr, store flag, data, pend_tag and the latched fill data.

## Test plan
- Reset low mid-WAIT -> state IDLE, req_ready=1, proc2mem_command=0 immediately. A later mem2proc_tag=3 causes no cm_wr0_en.
- Store 0x1111 to 0x0000_0408, then load from the same address (hit) -> cm_wr1_en idx=1, tag=1; load resp_data=0x1111 one cycle after acceptance.
- Load miss on 0x0000_0800, response=5 on the 2nd try, tag 5 after 10 cycles with data 0xABCD -> cm_wr0_en idx=0, tag=2; resp_data=0xABCD.
- Load 0x0000_0C00 with victim dirty, tag 2, data 0x77 -> BUS_STORE addr 0x800 data 0x77 first, then BUS_LOAD addr 0xC00.
- Store miss with clean victim -> no bus traffic; cm_wr1_en the cycle after acceptance; resp_valid follows.
- Back-to-back hits for 8 cycles -> 8 resp_valid pulses with no bubbles; req_ready held at 1.
